// File: rtl/wb_spi_initiator.sv
// Wishbone-mapped SPI mode-0 initiator: 32-bit MSB-first frames, 4-register window.
// Optional SPI_LOOPBACK_EN adds CTRL[10] loopback (samples copi, keeps CS high).
module wb_spi_initiator #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned DIV_W     = 8
) (
    input  logic        wb_clk_i,
    input  logic        resetn,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        spi_sck,
    output logic        spi_cs,
    output logic        spi_copi,
    input  logic        spi_cipo,
    output logic        busy,
    output logic        irq
);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, TAIL} state_t;

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             ack_q;
    logic [DIV_W-1:0] clkdiv_q, cnt_q;
    logic             cs_hold_q, irq_en_q, lb_q;
    logic             rx_valid_q, overrun_q, tx_drop_q;
    logic [31:0]      rxdata_q, shreg_q;
    logic [5:0]       bitcnt_q;
    logic             sck_q, cs_q, copi_q;

    logic        valid, rd, wr;
    logic        wr_ctrl, wr_status, wr_tx, rd_rx, tx_go;
    logic [31:0] lane_mask, ctrl_rd, ctrl_wr;
    logic [3:0]  w1c;
    logic        cs_hold_n, tick, rise, fall, done, sample;
    logic        unused_ok;

    assign valid = wbs_cyc_i & wbs_stb_i
                 & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign rd = ack_q & ~wbs_we_i;
    assign wr = ack_q & wbs_we_i;

    assign wr_ctrl   = wr & (wbs_adr_i[3:2] == 2'd0);
    assign wr_status = wr & (wbs_adr_i[3:2] == 2'd1);
    assign wr_tx     = wr & (wbs_adr_i[3:2] == 2'd2);
    assign rd_rx     = rd & (wbs_adr_i[3:2] == 2'd3);
    assign tx_go     = wr_tx & (state_q == IDLE);

    assign lane_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                        {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[DIV_W-1:0] = clkdiv_q;
        ctrl_rd[8]  = cs_hold_q;
        ctrl_rd[9]  = irq_en_q;
        ctrl_rd[10] = lb_q;
    end

    assign ctrl_wr   = (ctrl_rd & ~lane_mask) | (wbs_dat_i & lane_mask);
    assign cs_hold_n = wr_ctrl ? ctrl_wr[8] : cs_hold_q;
    assign w1c       = wr_status ? (wbs_dat_i[3:0] & lane_mask[3:0]) : 4'b0;
    assign sample    = lb_q ? copi_q : spi_cipo;
    assign tick      = (cnt_q == '0);
    assign unused_ok = ^{wbs_adr_i[1:0], ctrl_wr};

    always_comb begin
        wbs_dat_o = '0;
        if (rd) begin
            unique case (wbs_adr_i[3:2])
                2'd0:    wbs_dat_o = ctrl_rd;
                2'd1:    wbs_dat_o = {28'b0, tx_drop_q, overrun_q,
                                      rx_valid_q, busy};
                2'd3:    wbs_dat_o = rxdata_q;
                default: wbs_dat_o = '0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        rise    = 1'b0;
        fall    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE:  if (tx_go) state_d = SETUP;
            SETUP: if (tick) begin state_d = HIGH; rise = 1'b1; end
            HIGH:  if (tick) begin
                       fall    = 1'b1;
                       state_d = (bitcnt_q == 6'd32) ? TAIL : LOW;
                   end
            LOW:   if (tick) begin state_d = HIGH; rise = 1'b1; end
            TAIL:  if (tick) begin state_d = IDLE; done = 1'b1; end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!resetn) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            clkdiv_q   <= '0;
            cnt_q      <= '0;
            cs_hold_q  <= 1'b0;
            irq_en_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            tx_drop_q  <= 1'b0;
            rxdata_q   <= '0;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            sck_q      <= 1'b0;
            cs_q       <= 1'b1;
            copi_q     <= 1'b0;
        end else begin
            ack_q   <= valid & ~ack_q;
            state_q <= state_d;
            if (state_d != state_q) cnt_q <= clkdiv_q;
            else if (!tick)         cnt_q <= cnt_q - CNT_ONE;

            if (wr_ctrl) begin
                clkdiv_q  <= ctrl_wr[DIV_W-1:0];
                cs_hold_q <= ctrl_wr[8];
                irq_en_q  <= ctrl_wr[9];
            end
            if (wr_tx && state_q != IDLE) tx_drop_q <= 1'b1;
            else if (w1c[3])              tx_drop_q <= 1'b0;

            if (tx_go) begin
                shreg_q  <= wbs_dat_i & lane_mask;
                copi_q   <= wbs_dat_i[31] & wbs_sel_i[3];
                bitcnt_q <= '0;
                cs_q     <= lb_q;
            end else if (state_q == IDLE && !cs_hold_n) begin
                cs_q <= 1'b1;
            end

            if (rise) begin
                shreg_q  <= {shreg_q[30:0], sample};
                bitcnt_q <= bitcnt_q + 6'd1;
                sck_q    <= 1'b1;
            end
            if (fall) begin
                sck_q <= 1'b0;
                if (bitcnt_q != 6'd32) copi_q <= shreg_q[31];
            end

            // Completion overrides any same-cycle clear of rx_valid.
            if (done) begin
                rxdata_q   <= shreg_q;
                rx_valid_q <= 1'b1;
                overrun_q  <= (overrun_q & ~w1c[2])
                            | (rx_valid_q & ~w1c[1] & ~rd_rx);
                copi_q     <= 1'b0;
                if (!cs_hold_q) cs_q <= 1'b1;
            end else begin
                if (w1c[1] | rd_rx) rx_valid_q <= 1'b0;
                if (w1c[2])         overrun_q  <= 1'b0;
            end
        end
    end

`ifdef SPI_LOOPBACK_EN
    always_ff @(posedge wb_clk_i) begin
        if (!resetn)      lb_q <= 1'b0;
        else if (wr_ctrl) lb_q <= ctrl_wr[10];
    end
`else
    assign lb_q = 1'b0;
`endif

    assign wbs_ack_o = ack_q;
    assign spi_sck   = sck_q;
    assign spi_cs    = cs_q;
    assign spi_copi  = copi_q;
    assign busy      = (state_q != IDLE);
    assign irq       = rx_valid_q & irq_en_q;

endmodule

// File: tb/tb_wb_spi_initiator.sv
// Directed bench for wb_spi_initiator: WB register access, SPI frames,
// overrun/tx_drop, cs_hold, mid-frame reset and (if enabled) loopback.
module tb_wb_spi_initiator;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_TX   = BASE + 32'h8;
    localparam logic [31:0] A_RX   = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, dat = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic        sck, cs, copi, cipo, busy, irq;

    int checks = 0;
    int passed = 0;

    logic [4:0]  rcnt = '0;
    logic [31:0] resp = '0;
    logic [31:0] copi_cap = '0;
    int          rise_total = 0;
    int          cs_rises = 0;
    int          cs_falls = 0;
    time         t_prev = 0, t_last = 0;

    always #5 clk = ~clk;

    wb_spi_initiator #(.BASE_ADDR(BASE), .DIV_W(8)) dut (
        .wb_clk_i (clk),
        .resetn   (resetn),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_o),
        .spi_sck  (sck),
        .spi_cs   (cs),
        .spi_copi (copi),
        .spi_cipo (cipo),
        .busy     (busy),
        .irq      (irq)
    );

    // Responder model: presents resp MSB-first, next bit after each rising edge.
    always @(posedge sck or negedge resetn)
        if (!resetn) rcnt <= '0;
        else         rcnt <= rcnt + 5'd1;
    assign cipo = resp[~rcnt];

    always @(posedge sck) begin
        copi_cap = {copi_cap[30:0], copi};
        rise_total++;
        t_prev = t_last;
        t_last = $time;
    end
    always @(posedge cs) cs_rises++;
    always @(negedge cs) cs_falls++;

    task automatic wb_xfer(input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] q);
        bit got = 0;
        q = '0;
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) begin got = 1; q = dat_o; break; end
        end
        if (got) begin
            @(posedge clk); #1;
        end else begin
            checks++;
            $display("FAIL wb_ack adr=%h: no ack within 8 cycles", a);
        end
        cyc = 0; stb = 0; we = 0; sel = 4'h0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, a, d, 4'hF, q);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] q);
        wb_xfer(1'b0, a, 32'h0, 4'hF, q);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            n++;
            if (!busy) return;
        end
        checks++;
        $display("FAIL frame_timeout: busy still 1 after %0d cycles", n);
    endtask

    task automatic test_reset();
        logic [31:0] q;
        bit got = 0;
        resetn = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (sck !== 1'b0) $display("FAIL rst_sck got %b want 0", sck); else passed++;
        checks++; if (cs !== 1'b1) $display("FAIL rst_cs got %b want 1", cs); else passed++;
        checks++; if (copi !== 1'b0) $display("FAIL rst_copi got %b want 0", copi); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
        checks++; if (irq !== 1'b0) $display("FAIL rst_irq got %b want 0", irq); else passed++;
        checks++; if (ack !== 1'b0 || dat_o !== 32'h0)
            $display("FAIL rst_wb got ack=%b dat=%h want 0/0", ack, dat_o); else passed++;
        @(negedge clk) resetn = 1;
        wb_read(A_CTRL, q);
        checks++; if (q !== 32'h0) $display("FAIL rst_ctrl got %h want 0", q); else passed++;
        wb_read(A_STAT, q);
        checks++; if (q !== 32'h0) $display("FAIL rst_status got %h want 0", q); else passed++;
        wb_read(A_RX, q);
        checks++; if (q !== 32'h0) $display("FAIL rst_rxdata got %h want 0", q); else passed++;
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = BASE + 32'h10;
        repeat (5) begin
            @(posedge clk); #1;
            if (ack) got = 1;
        end
        cyc = 0; stb = 0;
        checks++; if (got !== 1'b0) $display("FAIL out_of_window_ack got 1 want 0"); else passed++;
    endtask

    task automatic test_frame();
        logic [31:0] q;
        logic [31:0] w;
        int n, r0;
        wb_xfer(1'b1, A_CTRL, 32'hFFFF_FF05, 4'b0001, w);
        wb_read(A_CTRL, q);
        checks++; if (q !== 32'h0000_0005) $display("FAIL byte_lane_ctrl got %h want 00000005", q); else passed++;
        wb_write(A_CTRL, 32'h0000_0201);
        resp = 32'h1234_5678;
        r0 = rise_total;
        wb_write(A_TX, 32'hA5C3_0F81);
        checks++; if (busy !== 1'b1 || cs !== 1'b0)
            $display("FAIL frame_start got busy=%b cs=%b want 1/0", busy, cs); else passed++;
        wait_idle(n);
        checks++; if (n !== 130) $display("FAIL frame_len got %0d cycles want 130", n); else passed++;
        checks++; if (rise_total - r0 !== 32)
            $display("FAIL rise_count got %0d want 32", rise_total - r0); else passed++;
        checks++; if (copi_cap !== 32'hA5C3_0F81)
            $display("FAIL copi_bits got %h want a5c30f81", copi_cap); else passed++;
        checks++; if (t_last - t_prev !== 40)
            $display("FAIL sck_period got %0t want 40", t_last - t_prev); else passed++;
        checks++; if (cs !== 1'b1 || sck !== 1'b0)
            $display("FAIL frame_end got cs=%b sck=%b want 1/0", cs, sck); else passed++;
        checks++; if (irq !== 1'b1) $display("FAIL irq_set got %b want 1", irq); else passed++;
        wb_read(A_STAT, q);
        checks++; if (q !== 32'h2) $display("FAIL status_rxv got %h want 2", q); else passed++;
        wb_read(A_RX, q);
        checks++; if (q !== 32'h1234_5678) $display("FAIL rxdata got %h want 12345678", q); else passed++;
        wb_read(A_STAT, q);
        checks++; if (q !== 32'h0) $display("FAIL rx_read_clear got %h want 0", q); else passed++;
        checks++; if (irq !== 1'b0) $display("FAIL irq_clear got %b want 0", irq); else passed++;
    endtask

    task automatic test_overrun();
        logic [31:0] q;
        int n;
        resp = 32'hCAFE_F00D;
        wb_write(A_TX, 32'h0000_0001);
        wait_idle(n);
        resp = 32'h0BAD_1DEA;
        wb_write(A_TX, 32'h8000_0000);
        wait_idle(n);
        wb_read(A_STAT, q);
        checks++; if (q !== 32'h6) $display("FAIL overrun_status got %h want 6", q); else passed++;
        wb_write(A_STAT, 32'h6);
        wb_read(A_STAT, q);
        checks++; if (q !== 32'h0) $display("FAIL w1c_clear got %h want 0", q); else passed++;
        wb_read(A_RX, q);
        checks++; if (q !== 32'h0BAD_1DEA) $display("FAIL overrun_rxdata got %h want 0bad1dea", q); else passed++;
    endtask

    task automatic test_tx_drop();
        logic [31:0] q;
        int n;
        resp = 32'h7777_0001;
        wb_write(A_TX, 32'h0F0F_3C3C);
        repeat (20) @(posedge clk);
        wb_write(A_TX, 32'hFFFF_FFFF);
        checks++; if (busy !== 1'b1) $display("FAIL drop_busy got %b want 1", busy); else passed++;
        wait_idle(n);
        checks++; if (copi_cap !== 32'h0F0F_3C3C)
            $display("FAIL drop_copi got %h want 0f0f3c3c", copi_cap); else passed++;
        wb_read(A_STAT, q);
        checks++; if (q !== 32'hA) $display("FAIL drop_status got %h want a", q); else passed++;
        wb_read(A_RX, q);
        checks++; if (q !== 32'h7777_0001) $display("FAIL drop_rxdata got %h want 77770001", q); else passed++;
        wb_write(A_STAT, 32'h8);
        wb_read(A_STAT, q);
        checks++; if (q !== 32'h0) $display("FAIL drop_clear got %h want 0", q); else passed++;
    endtask

    task automatic test_cs_hold();
        logic [31:0] q;
        int n, cr0;
        wb_write(A_CTRL, 32'h0000_0301);
        cr0 = cs_rises;
        resp = 32'h1111_2222;
        wb_write(A_TX, 32'h3333_4444);
        wait_idle(n);
        checks++; if (cs !== 1'b0) $display("FAIL hold_between got cs=%b want 0", cs); else passed++;
        resp = 32'h5555_6666;
        wb_write(A_TX, 32'h7777_8888);
        wait_idle(n);
        checks++; if (cs_rises - cr0 !== 0)
            $display("FAIL hold_rises got %0d want 0", cs_rises - cr0); else passed++;
        checks++; if (copi_cap !== 32'h7777_8888)
            $display("FAIL hold_copi got %h want 77778888", copi_cap); else passed++;
        wb_read(A_STAT, q);
        checks++; if (q !== 32'h6) $display("FAIL hold_status got %h want 6", q); else passed++;
        checks++; if (cs !== 1'b0) $display("FAIL hold_pre_release got %b want 0", cs); else passed++;
        wb_write(A_CTRL, 32'h0000_0201);
        checks++; if (cs !== 1'b1) $display("FAIL hold_release got cs=%b want 1", cs); else passed++;
        wb_read(A_RX, q);
        checks++; if (q !== 32'h5555_6666) $display("FAIL hold_rxdata got %h want 55556666", q); else passed++;
        wb_write(A_STAT, 32'hE);
    endtask

    task automatic test_reset_mid();
        logic [31:0] q;
        int n, r0;
        bit hit = 0;
        resp = 32'hFFFF_0000;
        r0 = rise_total;
        wb_write(A_TX, 32'hAAAA_5555);
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (rise_total - r0 >= 17) begin hit = 1; break; end
        end
        checks++; if (!hit) $display("FAIL mid_reach_bit17 got %0d rises want 17", rise_total - r0); else passed++;
        @(negedge clk) resetn = 0;
        @(posedge clk); #1;
        checks++; if (cs !== 1'b1 || sck !== 1'b0 || busy !== 1'b0)
            $display("FAIL mid_reset got cs=%b sck=%b busy=%b want 1/0/0", cs, sck, busy); else passed++;
        @(negedge clk) resetn = 1;
        resp = 32'h89AB_CDEF;
        wb_write(A_TX, 32'h1357_9BDF);
        wait_idle(n);
        checks++; if (n !== 65) $display("FAIL post_reset_len got %0d want 65", n); else passed++;
        checks++; if (copi_cap !== 32'h1357_9BDF)
            $display("FAIL post_reset_copi got %h want 13579bdf", copi_cap); else passed++;
        wb_read(A_RX, q);
        checks++; if (q !== 32'h89AB_CDEF) $display("FAIL post_reset_rx got %h want 89abcdef", q); else passed++;
    endtask

    task automatic test_loopback();
        logic [31:0] q;
        int n, cf0;
        wb_write(A_CTRL, 32'h0000_0401);
        wb_read(A_CTRL, q);
`ifdef SPI_LOOPBACK_EN
        checks++; if (q !== 32'h401) $display("FAIL lb_ctrl got %h want 401", q); else passed++;
        resp = 32'h0000_0000;
        cf0 = cs_falls;
        wb_write(A_TX, 32'hDEAD_BEEF);
        wait_idle(n);
        checks++; if (cs_falls - cf0 !== 0 || cs !== 1'b1)
            $display("FAIL lb_cs got falls=%0d cs=%b want 0/1", cs_falls - cf0, cs); else passed++;
        wb_read(A_RX, q);
        checks++; if (q !== 32'hDEAD_BEEF) $display("FAIL lb_rx got %h want deadbeef", q); else passed++;
`else
        checks++; if (q !== 32'h001) $display("FAIL lb_ctrl_ignored got %h want 1", q); else passed++;
        resp = 32'h5555_AAAA;
        cf0 = cs_falls;
        wb_write(A_TX, 32'hDEAD_BEEF);
        wait_idle(n);
        checks++; if (cs_falls - cf0 !== 1)
            $display("FAIL nolb_cs got falls=%0d want 1", cs_falls - cf0); else passed++;
        wb_read(A_RX, q);
        checks++; if (q !== 32'h5555_AAAA) $display("FAIL nolb_rx got %h want 5555aaaa", q); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_frame();
        test_overrun();
        test_tx_drop();
        test_cs_hold();
        test_reset_mid();
        test_loopback();
        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
